// File: rtl/tlb.sv
// tlb: 16-entry fully-associative MIPS32 joint TLB with CP0 side-band.
// Executes TLBWI/TLBWR/TLBR/TLBP via a two-state FSM and provides two
// translation ports (s0 fetch, s1 data/probe).
// Optional macro TLB_LOOKUP_REG_EN registers the lookup outputs (1-cycle
// latency); TLBP then uses a separate unregistered probe compare.
module tlb #(
  parameter int unsigned TLBNUM = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [1:0]  op_type,
  output logic        op_ready,
  output logic        op_done,
  output logic        tlb_busy,
  input  logic [31:0] EntryHi_out,
  input  logic [31:0] EntryLo0_out,
  input  logic [31:0] EntryLo1_out,
  input  logic [31:0] Index_out,
  input  logic [31:0] Random_out,
  output logic        EntryHi_Wren,
  output logic        EntryLo0_Wren,
  output logic        EntryLo1_Wren,
  output logic        Index_Wren,
  output logic [31:0] EntryHi_in,
  output logic [31:0] EntryLo0_in,
  output logic [31:0] EntryLo1_in,
  output logic [31:0] Index_in,
  output logic        s1_found,
  input  logic [31:0] s0_vaddr,
  input  logic [31:0] s1_vaddr,
  output logic        s0_found,
  output logic [31:0] s0_paddr,
  output logic [2:0]  s0_c,
  output logic        s0_d,
  output logic        s0_v,
  output logic [31:0] s1_paddr,
  output logic [2:0]  s1_c,
  output logic        s1_d,
  output logic        s1_v,
  output logic [3:0]  s1_index
);

  typedef enum logic {S_IDLE = 1'b0, S_EXEC = 1'b1} state_e;
  typedef enum logic [1:0] {
    OP_TLBWI = 2'b00,
    OP_TLBWR = 2'b01,
    OP_TLBR  = 2'b10,
    OP_TLBP  = 2'b11
  } op_e;

  state_e r_state;
  state_e w_next;
  op_e    r_op;
  logic   w_we;

  // Per-entry storage; a page word is {PFN[19:0], C[2:0], D, V}.
  logic [18:0] r_vpn2 [TLBNUM];
  logic [7:0]  r_asid [TLBNUM];
  logic        r_g    [TLBNUM];
  logic [24:0] r_pg0  [TLBNUM];
  logic [24:0] r_pg1  [TLBNUM];

  logic [3:0]  w_widx;
  logic [3:0]  w_ridx;
  logic        w_pr_exec;
  logic [31:0] w_s1_va;

  logic [TLBNUM-1:0] w_s0_hit;
  logic [TLBNUM-1:0] w_s1_hit;
  logic [TLBNUM-1:0] w_pr_hit;
  logic        w_s0_found, w_s1_found, w_pr_found;
  logic [3:0]  w_s0_idx, w_s1_idx, w_pr_idx;
  logic [24:0] w_s0_pg, w_s1_pg;
  logic [31:0] w_s0_paddr, w_s1_paddr;

  // State register and latched operation type.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_op    <= OP_TLBWI;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && op_valid) r_op <= op_e'(op_type);
    end
  end

  // Next-state decode and per-operation strobes.
  always_comb begin
    w_next        = r_state;
    op_ready      = 1'b0;
    op_done       = 1'b0;
    w_we          = 1'b0;
    EntryHi_Wren  = 1'b0;
    EntryLo0_Wren = 1'b0;
    EntryLo1_Wren = 1'b0;
    Index_Wren    = 1'b0;
    case (r_state)
      S_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) w_next = S_EXEC;
      end
      S_EXEC: begin
        op_done = 1'b1;
        w_next  = S_IDLE;
        case (r_op)
          OP_TLBWI, OP_TLBWR: w_we = 1'b1;
          OP_TLBR: begin
            EntryHi_Wren  = 1'b1;
            EntryLo0_Wren = 1'b1;
            EntryLo1_Wren = 1'b1;
          end
          default: Index_Wren = 1'b1;
        endcase
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign tlb_busy  = ~op_ready;
  assign w_pr_exec = (r_state == S_EXEC) && (r_op == OP_TLBP);
  assign w_widx    = (r_op == OP_TLBWR) ? Random_out[3:0] : Index_out[3:0];
  assign w_ridx    = Index_out[3:0];

  // Entry array: cleared on reset, written at the edge ending a TLBW EXEC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < TLBNUM; i++) begin
        r_vpn2[i] <= '0;
        r_asid[i] <= '0;
        r_g[i]    <= 1'b0;
        r_pg0[i]  <= '0;
        r_pg1[i]  <= '0;
      end
    end else if (w_we) begin
      r_vpn2[w_widx] <= EntryHi_out[31:13];
      r_asid[w_widx] <= EntryHi_out[7:0];
      r_g[w_widx]    <= EntryLo0_out[0] & EntryLo1_out[0];
      r_pg0[w_widx]  <= EntryLo0_out[25:1];
      r_pg1[w_widx]  <= EntryLo1_out[25:1];
    end
  end

  // TLBR read-back reassembles the CP0 register layouts.
  assign EntryHi_in  = {r_vpn2[w_ridx], 5'b0, r_asid[w_ridx]};
  assign EntryLo0_in = {6'b0, r_pg0[w_ridx], r_g[w_ridx]};
  assign EntryLo1_in = {6'b0, r_pg1[w_ridx], r_g[w_ridx]};
  assign Index_in    = {28'b0, w_pr_idx};

`ifdef TLB_LOOKUP_REG_EN
  assign w_s1_va = s1_vaddr;
`else
  // During TLBP EXEC the s1 port is borrowed for the probe compare.
  assign w_s1_va = w_pr_exec ? {EntryHi_out[31:13], 13'b0} : s1_vaddr;
`endif

  for (genvar g = 0; g < TLBNUM; g++) begin : g_hit
    assign w_s0_hit[g] = (r_vpn2[g] == s0_vaddr[31:13]) &&
                         (r_g[g] || r_asid[g] == EntryHi_out[7:0]);
    assign w_s1_hit[g] = (r_vpn2[g] == w_s1_va[31:13]) &&
                         (r_g[g] || r_asid[g] == EntryHi_out[7:0]);
    assign w_pr_hit[g] = (r_vpn2[g] == EntryHi_out[31:13]) &&
                         (r_g[g] || r_asid[g] == EntryHi_out[7:0]);
  end

  // Priority-encode each hit vector to its lowest set index.
  always_comb begin
    w_s0_found = 1'b0;
    w_s1_found = 1'b0;
    w_pr_found = 1'b0;
    w_s0_idx   = '0;
    w_s1_idx   = '0;
    w_pr_idx   = '0;
    for (int unsigned i = 0; i < TLBNUM; i++) begin
      if (w_s0_hit[i] && !w_s0_found) begin
        w_s0_found = 1'b1;
        w_s0_idx   = 4'(i);
      end
      if (w_s1_hit[i] && !w_s1_found) begin
        w_s1_found = 1'b1;
        w_s1_idx   = 4'(i);
      end
      if (w_pr_hit[i] && !w_pr_found) begin
        w_pr_found = 1'b1;
        w_pr_idx   = 4'(i);
      end
    end
  end

  // Select the even/odd page of the hit entry; a miss yields all zeros.
  always_comb begin
    w_s0_pg = '0;
    w_s1_pg = '0;
    if (w_s0_found) w_s0_pg = s0_vaddr[12] ? r_pg1[w_s0_idx] : r_pg0[w_s0_idx];
    if (w_s1_found) w_s1_pg = w_s1_va[12]  ? r_pg1[w_s1_idx] : r_pg0[w_s1_idx];
  end

  assign w_s0_paddr = w_s0_found ? {w_s0_pg[24:5], s0_vaddr[11:0]} : '0;
  assign w_s1_paddr = w_s1_found ? {w_s1_pg[24:5], w_s1_va[11:0]}  : '0;

`ifdef TLB_LOOKUP_REG_EN
  logic        r_s0_found, r_s1_found;
  logic [31:0] r_s0_paddr, r_s1_paddr;
  logic [2:0]  r_s0_c, r_s1_c;
  logic        r_s0_d, r_s1_d, r_s0_v, r_s1_v;
  logic [3:0]  r_s1_index;

  // Registered lookup results, one cycle behind the vaddr inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s0_found <= 1'b0;
      r_s1_found <= 1'b0;
      r_s0_paddr <= '0;
      r_s1_paddr <= '0;
      r_s0_c     <= '0;
      r_s1_c     <= '0;
      r_s0_d     <= 1'b0;
      r_s1_d     <= 1'b0;
      r_s0_v     <= 1'b0;
      r_s1_v     <= 1'b0;
      r_s1_index <= '0;
    end else begin
      r_s0_found <= w_s0_found;
      r_s1_found <= w_s1_found;
      r_s0_paddr <= w_s0_paddr;
      r_s1_paddr <= w_s1_paddr;
      r_s0_c     <= w_s0_pg[4:2];
      r_s1_c     <= w_s1_pg[4:2];
      r_s0_d     <= w_s0_pg[1];
      r_s1_d     <= w_s1_pg[1];
      r_s0_v     <= w_s0_pg[0];
      r_s1_v     <= w_s1_pg[0];
      r_s1_index <= w_s1_idx;
    end
  end

  assign s0_found = r_s0_found;
  assign s0_paddr = r_s0_paddr;
  assign s0_c     = r_s0_c;
  assign s0_d     = r_s0_d;
  assign s0_v     = r_s0_v;
  // Probe result bypasses the register so CP0 sees it within EXEC.
  assign s1_found = w_pr_exec ? w_pr_found : r_s1_found;
  assign s1_paddr = r_s1_paddr;
  assign s1_c     = r_s1_c;
  assign s1_d     = r_s1_d;
  assign s1_v     = r_s1_v;
  assign s1_index = w_pr_exec ? w_pr_idx : r_s1_index;
`else
  assign s0_found = w_s0_found;
  assign s0_paddr = w_s0_paddr;
  assign s0_c     = w_s0_pg[4:2];
  assign s0_d     = w_s0_pg[1];
  assign s0_v     = w_s0_pg[0];
  assign s1_found = w_s1_found;
  assign s1_paddr = w_s1_paddr;
  assign s1_c     = w_s1_pg[4:2];
  assign s1_d     = w_s1_pg[1];
  assign s1_v     = w_s1_pg[0];
  assign s1_index = w_s1_idx;
`endif

  logic w_unused_bits;
  assign w_unused_bits = ^{EntryHi_out[12:8], EntryLo0_out[31:26], EntryLo1_out[31:26],
                           Index_out[31:4], Random_out[31:4], w_pr_found};

endmodule

// File: tb/tb_tlb.sv
// tb_tlb: scoreboard bench for tlb with a behavioural entry-table model.
module tb_tlb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        op_valid = 1'b0;
  logic [1:0]  op_type = '0;
  logic        op_ready, op_done, tlb_busy;
  logic [31:0] EntryHi_out = '0, EntryLo0_out = '0, EntryLo1_out = '0;
  logic [31:0] Index_out = '0, Random_out = '0;
  logic        EntryHi_Wren, EntryLo0_Wren, EntryLo1_Wren, Index_Wren;
  logic [31:0] EntryHi_in, EntryLo0_in, EntryLo1_in, Index_in;
  logic        s1_found, s0_found;
  logic [31:0] s0_vaddr = '0, s1_vaddr = '0;
  logic [31:0] s0_paddr, s1_paddr;
  logic [2:0]  s0_c, s1_c;
  logic        s0_d, s1_d, s0_v, s1_v;
  logic [3:0]  s1_index;

  always #5 clk = ~clk;

  tlb #(.TLBNUM(16)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_type(op_type),
    .op_ready(op_ready), .op_done(op_done), .tlb_busy(tlb_busy),
    .EntryHi_out(EntryHi_out), .EntryLo0_out(EntryLo0_out), .EntryLo1_out(EntryLo1_out),
    .Index_out(Index_out), .Random_out(Random_out),
    .EntryHi_Wren(EntryHi_Wren), .EntryLo0_Wren(EntryLo0_Wren),
    .EntryLo1_Wren(EntryLo1_Wren), .Index_Wren(Index_Wren),
    .EntryHi_in(EntryHi_in), .EntryLo0_in(EntryLo0_in), .EntryLo1_in(EntryLo1_in),
    .Index_in(Index_in), .s1_found(s1_found),
    .s0_vaddr(s0_vaddr), .s1_vaddr(s1_vaddr),
    .s0_found(s0_found), .s0_paddr(s0_paddr), .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
    .s1_paddr(s1_paddr), .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v), .s1_index(s1_index)
  );

  // Reference model: raw CP0 fields as last written to each entry.
  logic [18:0] m_vpn2 [16];
  logic [7:0]  m_asid [16];
  logic        m_g    [16];
  logic [25:0] m_lo0  [16];
  logic [25:0] m_lo1  [16];

  typedef struct packed {
    logic        s0f;
    logic [31:0] s0pa;
    logic [2:0]  s0c;
    logic        s0d, s0v;
    logic        s1f;
    logic [31:0] s1pa;
    logic [2:0]  s1c;
    logic        s1d, s1v;
    logic [3:0]  s1i;
  } lk_t;

  typedef struct packed {
    logic [1:0]  t;
    logic [3:0]  wren;
    logic [31:0] hi, lo0, lo1, idx;
    logic        f;
  } op_t;

  lk_t lk_q[$];
  op_t op_q[$];
  logic lk_valid = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  logic [31:0] va0, va1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void mdl_clear();
    for (int i = 0; i < 16; i++) begin
      m_vpn2[i] = '0; m_asid[i] = '0; m_g[i] = 1'b0; m_lo0[i] = '0; m_lo1[i] = '0;
    end
  endfunction

  function automatic void mdl_lk(input logic [31:0] va, input logic [7:0] asid,
                                 output logic f, output logic [31:0] pa, output logic [2:0] c,
                                 output logic d, output logic v, output logic [3:0] idx);
    logic [25:0] lo;
    f = 1'b0; pa = '0; c = '0; d = 1'b0; v = 1'b0; idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (!f && m_vpn2[i] == va[31:13] && (m_g[i] || m_asid[i] == asid)) begin
        f   = 1'b1;
        idx = 4'(i);
        lo  = va[12] ? m_lo1[i] : m_lo0[i];
        pa  = {lo[25:6], va[11:0]};
        c   = lo[5:3];
        d   = lo[2];
        v   = lo[1];
      end
    end
  endfunction

  function automatic lk_t exp_lk(input logic [31:0] a0, input logic [31:0] a1, input logic [7:0] asid);
    lk_t e;
    logic [3:0] dummy;
    mdl_lk(a0, asid, e.s0f, e.s0pa, e.s0c, e.s0d, e.s0v, dummy);
    mdl_lk(a1, asid, e.s1f, e.s1pa, e.s1c, e.s1d, e.s1v, e.s1i);
    return e;
  endfunction

  function automatic op_t exp_op(input logic [1:0] t);
    op_t o;
    int i;
    logic f, d, v;
    logic [31:0] pa;
    logic [2:0] c;
    logic [3:0] idx;
    o = '0;
    o.t = t;
    i = int'(Index_out[3:0]);
    if (t == 2'b10) begin
      o.wren = 4'b1110;
      o.hi   = {m_vpn2[i], 5'b0, m_asid[i]};
      o.lo0  = {6'b0, m_lo0[i][25:1], m_g[i]};
      o.lo1  = {6'b0, m_lo1[i][25:1], m_g[i]};
    end else if (t == 2'b11) begin
      o.wren = 4'b0001;
      mdl_lk({EntryHi_out[31:13], 13'b0}, EntryHi_out[7:0], f, pa, c, d, v, idx);
      o.f   = f;
      o.idx = {28'b0, idx};
    end
    return o;
  endfunction

  function automatic void mdl_write(input logic [1:0] t);
    int i;
    i = (t == 2'b01) ? int'(Random_out[3:0]) : int'(Index_out[3:0]);
    m_vpn2[i] = EntryHi_out[31:13];
    m_asid[i] = EntryHi_out[7:0];
    m_g[i]    = EntryLo0_out[0] & EntryLo1_out[0];
    m_lo0[i]  = EntryLo0_out[25:0];
    m_lo1[i]  = EntryLo1_out[25:0];
  endfunction

  function automatic logic [18:0] pick_vpn();
    case ($urandom_range(0, 3))
      0:       return 19'h00200;
      1:       return 19'h00201;
      2:       return 19'h7FFFF;
      default: return 19'h12345;
    endcase
  endfunction

  task automatic lookup(input logic [31:0] a0, input logic [31:0] a1);
    s0_vaddr = a0;
    s1_vaddr = a1;
    lk_q.push_back(exp_lk(a0, a1, EntryHi_out[7:0]));
    lk_valid = 1'b1;
    @(posedge clk); #1;
    lk_valid = 1'b0;
  endtask

  task automatic do_op(input logic [1:0] t, input bit with_lk, input logic [31:0] a);
    op_q.push_back(exp_op(t));
    op_type  = t;
    op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    if (with_lk) begin
      s0_vaddr = a;
      s1_vaddr = a ^ 32'h0000_1000;
      lk_q.push_back(exp_lk(a, a ^ 32'h0000_1000, EntryHi_out[7:0]));
      lk_valid = 1'b1;
    end
    @(posedge clk); #1;
    lk_valid = 1'b0;
    if (t[1] == 1'b0) mdl_write(t);
  endtask

  // Monitor: pops expectations whenever the DUT completes an op or a lookup is presented.
  always @(negedge clk) begin
    op_t o;
    lk_t e;
    if (op_done) begin
      done_cnt++;
      chk("exec_ready", 32'(op_ready), 32'd0);
      chk("exec_busy", 32'(tlb_busy), 32'd1);
      if (op_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL op_unexpected: got op_done=1 expected no pending op");
      end else begin
        o = op_q.pop_front();
        chk("wren", 32'({EntryHi_Wren, EntryLo0_Wren, EntryLo1_Wren, Index_Wren}), 32'(o.wren));
        if (o.t == 2'b10) begin
          chk("tlbr_hi", EntryHi_in, o.hi);
          chk("tlbr_lo0", EntryLo0_in, o.lo0);
          chk("tlbr_lo1", EntryLo1_in, o.lo1);
        end else if (o.t == 2'b11) begin
          chk("tlbp_found", 32'(s1_found), 32'(o.f));
          if (o.f) chk("tlbp_index", Index_in, o.idx);
        end
      end
    end else begin
      chk("wren_idle", 32'({EntryHi_Wren, EntryLo0_Wren, EntryLo1_Wren, Index_Wren}), 32'd0);
    end
    if (lk_valid) begin
      if (lk_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL lk_underflow: got lookup strobe expected queued entry");
      end else begin
        e = lk_q.pop_front();
        chk("s0_found", 32'(s0_found), 32'(e.s0f));
        chk("s0_paddr", s0_paddr, e.s0pa);
        chk("s0_c", 32'(s0_c), 32'(e.s0c));
        chk("s0_d", 32'(s0_d), 32'(e.s0d));
        chk("s0_v", 32'(s0_v), 32'(e.s0v));
        chk("s1_found", 32'(s1_found), 32'(e.s1f));
        chk("s1_paddr", s1_paddr, e.s1pa);
        chk("s1_c", 32'(s1_c), 32'(e.s1c));
        chk("s1_d", 32'(s1_d), 32'(e.s1d));
        chk("s1_v", 32'(s1_v), 32'(e.s1v));
        if (e.s1f) chk("s1_index", 32'(s1_index), 32'(e.s1i));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish before 2ms");
    $fatal(1);
  end

  initial begin
    int d0;
    mdl_clear();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Reset state
    chk("rst_ready", 32'(op_ready), 32'd1);
    chk("rst_done", 32'(op_done), 32'd0);
    chk("rst_busy", 32'(tlb_busy), 32'd0);
    lookup(32'h0040_0000, 32'h0040_0000);
    chk("rst_s0_found", 32'(s0_found), 32'd0);
    chk("rst_s0_paddr", s0_paddr, 32'd0);

    // TLBWI entry 3 and translate through the odd page
    Index_out = 32'd3; EntryHi_out = 32'h0040_0005;
    EntryLo0_out = 32'h0000_1016; EntryLo1_out = 32'h0000_1056;
    do_op(2'b00, 1'b0, '0);
    lookup(32'h0040_1ABC, 32'h0040_0ABC);
    chk("tp_found", 32'(s0_found), 32'd1);
    chk("tp_paddr", s0_paddr, 32'h0004_1ABC);
    chk("tp_v", 32'(s0_v), 32'd1);
    chk("tp_d", 32'(s0_d), 32'd1);
    chk("tp_c", 32'(s0_c), 32'd2);
    chk("tp_s1_paddr", s1_paddr, 32'h0004_0ABC);

    // TLBR of entry 3
    do_op(2'b10, 1'b0, '0);

    // ASID mismatch with G=0 misses; rewrite with G=1 hits
    EntryHi_out = 32'h0040_0006;
    lookup(32'h0040_1ABC, 32'h0040_0ABC);
    chk("asid_miss", 32'(s0_found), 32'd0);
    EntryHi_out = 32'h0040_0005;
    EntryLo0_out = 32'h0000_1017; EntryLo1_out = 32'h0000_1057;
    do_op(2'b00, 1'b0, '0);
    EntryHi_out = 32'h0040_0006;
    lookup(32'h0040_1ABC, 32'h0040_0ABC);
    chk("global_hit", 32'(s0_found), 32'd1);

    // Same-cycle lookup during a write sees the old contents
    Index_out = 32'd4; EntryHi_out = 32'hFFFF_E006;
    EntryLo0_out = 32'h0000_2002; EntryLo1_out = 32'h0000_2042;
    do_op(2'b00, 1'b1, 32'hFFFF_E123);
    lookup(32'hFFFF_E123, 32'hFFFF_F123);
    chk("new_visible", 32'(s0_found), 32'd1);

    // TLBP hit on entry 3 and a clean miss
    EntryHi_out = 32'h0040_0006;
    do_op(2'b11, 1'b0, '0);
    EntryHi_out = 32'h1234_0006;
    do_op(2'b11, 1'b0, '0);

    // op_valid held for 4 edges gives exactly 2 operations
    EntryHi_out = 32'h0040_0006;
    op_q.push_back(exp_op(2'b11));
    op_q.push_back(exp_op(2'b11));
    d0 = done_cnt;
    op_type = 2'b11;
    op_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1 op_valid = 1'b0;
    @(posedge clk); #1;
    chk("held_done_cnt", 32'(done_cnt - d0), 32'd2);

    // Reset during TLBWR EXEC aborts the write
    Random_out = 32'd5; EntryHi_out = 32'hF579_A002;
    EntryLo0_out = 32'h0000_3003; EntryLo1_out = 32'h0000_3043;
    op_type = 2'b01;
    op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    rst = 1'b0;
    mdl_clear();
    @(posedge clk); #1;
    rst = 1'b1;
    chk("abort_ready", 32'(op_ready), 32'd1);
    lookup(32'hF579_A010, 32'hF579_B010);
    chk("abort_miss", 32'(s0_found), 32'd0);
    Index_out = 32'd5;
    do_op(2'b10, 1'b0, '0);

    // Randomized operations and lookups
    for (int n = 0; n < 300; n++) begin
      int unsigned sel;
      sel = $urandom_range(0, 5);
      EntryHi_out  = {pick_vpn(), 5'($urandom()), 8'($urandom_range(1, 3))};
      Index_out    = $urandom();
      Random_out   = $urandom();
      EntryLo0_out = $urandom();
      EntryLo1_out = $urandom();
      va0 = {pick_vpn(), 13'($urandom())};
      va1 = {pick_vpn(), 13'($urandom())};
      case (sel)
        0, 1:    do_op(2'(sel), $urandom_range(0, 1) == 1, va0);
        2:       do_op(2'b10, 1'b0, '0);
        3:       do_op(2'b11, 1'b0, '0);
        default: lookup(va0, va1);
      endcase
    end

    repeat (2) @(posedge clk);
    #1;
    chk("op_q_empty", 32'(op_q.size()), 32'd0);
    chk("lk_q_empty", 32'(lk_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
